// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART 8O1 receive front-end with single-entry holding register and sticky fault flags
module uart_rx_frame #(
  parameter int BaudRate = 64
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       par_err,
  output logic       stp_err,
  output logic       break_det,
  output logic       break_active,
  output logic       overrun,
  input  logic       err_clr
);

  localparam logic [15:0] HALF_M1 = 16'(BaudRate / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(BaudRate - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic [15:0] r_baud_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_par_bit;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_par_err;
  logic        r_stp_err;
  logic        r_break_det;
  logic        r_break_active;
  logic        r_overrun;

  logic w_rxs;
  logic w_sample;
  logic w_stop_pt;
  logic w_par_ok;
  logic w_frame_ok;
  logic w_is_break;
  logic w_load;
  logic w_accept;

  assign w_rxs      = r_sync2;
  // Start bit is sampled at mid-bit; every later sample is one full bit period apart.
  assign w_sample   = (r_state == START) ? (r_baud_cnt == HALF_M1) : (r_baud_cnt == FULL_M1);
  assign w_stop_pt  = (r_state == STOP) && w_sample;
  assign w_par_ok   = ^{r_shift, r_par_bit};
  assign w_frame_ok = w_stop_pt && w_rxs && w_par_ok;
  assign w_is_break = (r_shift == 8'h00) && !r_par_bit;
  assign w_accept   = r_rx_valid && rx_ready;
  assign w_load     = w_frame_ok && (!r_rx_valid || rx_ready);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state        <= IDLE;
      r_sync1        <= 1'b1;
      r_sync2        <= 1'b1;
      r_baud_cnt     <= 16'd0;
      r_bit_idx      <= 3'd0;
      r_shift        <= 8'h00;
      r_par_bit      <= 1'b0;
      r_rx_data      <= 8'h00;
      r_rx_valid     <= 1'b0;
      r_par_err      <= 1'b0;
      r_stp_err      <= 1'b0;
      r_break_det    <= 1'b0;
      r_break_active <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_sync1 <= RX;
      r_sync2 <= r_sync1;

      case (r_state)
        IDLE: begin
          r_baud_cnt <= 16'd0;
          if (!w_rxs) r_state <= START;
        end
        START, DATA, PARITY, STOP: begin
          r_baud_cnt <= w_sample ? 16'd0 : r_baud_cnt + 16'd1;
          if (w_sample) begin
            case (r_state)
              START: begin
                r_bit_idx <= 3'd0;
                r_state   <= w_rxs ? IDLE : DATA;
              end
              DATA: begin
                r_shift[r_bit_idx] <= w_rxs;
                r_bit_idx          <= r_bit_idx + 3'd1;
                if (r_bit_idx == 3'd7) r_state <= PARITY;
              end
              PARITY: begin
                r_par_bit <= w_rxs;
                r_state   <= STOP;
              end
              default: begin
                if (w_rxs) begin
                  r_state <= IDLE;
                end else begin
                  r_state        <= BREAK;
                  r_break_active <= 1'b1;
                end
              end
            endcase
          end
        end
        default: begin
          r_baud_cnt <= 16'd0;
          if (w_rxs) begin
            r_state        <= IDLE;
            r_break_active <= 1'b0;
          end
        end
      endcase

      if (w_load) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (w_accept) begin
        r_rx_valid <= 1'b0;
      end

      // A set event in the same cycle as err_clr keeps the flag set.
      r_par_err   <= (w_stop_pt && w_rxs && !w_par_ok) || (r_par_err && !err_clr);
      r_stp_err   <= (w_stop_pt && !w_rxs && !w_is_break) || (r_stp_err && !err_clr);
      r_break_det <= (w_stop_pt && !w_rxs && w_is_break) || (r_break_det && !err_clr);
      r_overrun   <= (w_frame_ok && r_rx_valid && !rx_ready) || (r_overrun && !err_clr);
    end
  end

  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign par_err      = r_par_err;
  assign stp_err      = r_stp_err;
  assign break_det    = r_break_det;
  assign break_active = r_break_active;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - randomized self-checking bench for uart_rx_frame against a frame-level model
module tb_uart_rx_frame;

  localparam int B = 8;
  localparam int LAT = 3 + B / 2 + 10 * B;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       RX = 1'b1;
  logic       rx_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       par_err;
  logic       stp_err;
  logic       break_det;
  logic       break_active;
  logic       overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_rise = -1;
  int hi_cycles = 0;
  logic prev_valid = 1'b0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  uart_rx_frame #(.BaudRate(B)) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .RX(RX),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .par_err(par_err),
    .stp_err(stp_err),
    .break_det(break_det),
    .break_active(break_active),
    .overrun(overrun),
    .err_clr(err_clr)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (rx_valid && !prev_valid) last_rise <= cyc;
    if (rx_valid) hi_cycles <= hi_cycles + 1;
    if (rx_valid && rx_ready) got.push_back(rx_data);
    prev_valid <= rx_valid;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  task automatic drive_bits(input logic [7:0] d, input logic p, input logic s, input int nbits);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int k = 0; k < nbits; k++) begin
      RX = f[k];
      wait_cyc(B);
    end
  endtask

  task automatic send_good(input logic [7:0] d);
    drive_bits(d, odd_par(d), 1'b1, 11);
    RX = 1'b1;
    wait_cyc(6);
  endtask

  task automatic pulse_clr;
    err_clr = 1'b1;
    wait_cyc(1);
    err_clr = 1'b0;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    RX = 1'b1;
    wait_cyc(3);
    checks++;
    if ({rx_data, rx_valid} !== 9'h000) begin
      failures++;
      $display("FAIL reset_data: got data=%h valid=%b, want 00/0", rx_data, rx_valid);
    end
    checks++;
    if ({par_err, stp_err, break_det, break_active, overrun} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b, want 00000", {par_err, stp_err, break_det, break_active, overrun});
    end
    Rst_n = 1'b1;
    wait_cyc(4);
  endtask

  task automatic test_good_frame;
    int t0;
    int h0;
    rx_ready = 1'b1;
    pulse_clr();
    got.delete();
    h0 = hi_cycles;
    t0 = cyc;
    send_good(8'hA5);
    checks++;
    if (got.size() != 1 || got[0] !== 8'hA5) begin
      failures++;
      $display("FAIL good_data: got %0d bytes first=%h, want 1 byte A5", got.size(), (got.size() > 0) ? got[0] : 8'hxx);
    end
    checks++;
    if (last_rise != t0 + LAT) begin
      failures++;
      $display("FAIL good_latency: rise at cycle %0d, want %0d", last_rise, t0 + LAT);
    end
    checks++;
    if (hi_cycles - h0 != 1) begin
      failures++;
      $display("FAIL good_valid_width: high %0d cycles, want 1", hi_cycles - h0);
    end
    checks++;
    if ({par_err, stp_err, break_det, break_active, overrun} !== 5'b0) begin
      failures++;
      $display("FAIL good_flags: got %b, want 00000", {par_err, stp_err, break_det, break_active, overrun});
    end
  endtask

  task automatic test_parity_err;
    got.delete();
    drive_bits(8'h3C, 1'b0, 1'b1, 11);
    RX = 1'b1;
    wait_cyc(6);
    checks++;
    if (got.size() != 0 || par_err !== 1'b1) begin
      failures++;
      $display("FAIL parity_set: got %0d bytes par_err=%b, want 0 bytes par_err=1", got.size(), par_err);
    end
    pulse_clr();
    wait_cyc(1);
    checks++;
    if (par_err !== 1'b0) begin
      failures++;
      $display("FAIL parity_clear: par_err=%b, want 0", par_err);
    end
  endtask

  task automatic test_glitch;
    got.delete();
    RX = 1'b0;
    wait_cyc(3);
    RX = 1'b1;
    wait_cyc(12 * B);
    checks++;
    if (got.size() != 0 || rx_valid !== 1'b0 ||
        {par_err, stp_err, break_det, break_active, overrun} !== 5'b0) begin
      failures++;
      $display("FAIL glitch_quiet: bytes=%0d valid=%b flags=%b, want 0 0 00000", got.size(), rx_valid,
               {par_err, stp_err, break_det, break_active, overrun});
    end
    send_good(8'h5A);
    checks++;
    if (got.size() != 1 || got[0] !== 8'h5A) begin
      failures++;
      $display("FAIL glitch_next: got %0d bytes first=%h, want 1 byte 5A", got.size(), (got.size() > 0) ? got[0] : 8'hxx);
    end
  endtask

  task automatic test_break;
    int r;
    got.delete();
    RX = 1'b0;
    wait_cyc(12 * B);
    checks++;
    if (break_det !== 1'b1 || break_active !== 1'b1 || stp_err !== 1'b0 || par_err !== 1'b0) begin
      failures++;
      $display("FAIL break_set: det=%b active=%b stp=%b par=%b, want 1 1 0 0", break_det, break_active, stp_err, par_err);
    end
    r = cyc;
    RX = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if (break_active !== 1'b1 || cyc != r + 2) begin
      failures++;
      $display("FAIL break_hold: active=%b at cycle %0d, want 1 at %0d", break_active, cyc, r + 2);
    end
    @(negedge Clk);
    checks++;
    if (break_active !== 1'b0) begin
      failures++;
      $display("FAIL break_release: active=%b at cycle %0d, want 0", break_active, cyc);
    end
    wait_cyc(2);
    send_good(8'h81);
    checks++;
    if (got.size() != 1 || got[0] !== 8'h81) begin
      failures++;
      $display("FAIL break_next: got %0d bytes first=%h, want 1 byte 81", got.size(), (got.size() > 0) ? got[0] : 8'hxx);
    end
  endtask

  task automatic test_overrun;
    pulse_clr();
    rx_ready = 1'b0;
    got.delete();
    send_good(8'h11);
    send_good(8'h22);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11 || overrun !== 1'b1 || got.size() != 0) begin
      failures++;
      $display("FAIL overrun_set: valid=%b data=%h overrun=%b bytes=%0d, want 1 11 1 0",
               rx_valid, rx_data, overrun, got.size());
    end
    rx_ready = 1'b1;
    wait_cyc(1);
    rx_ready = 1'b0;
    wait_cyc(3 * B);
    checks++;
    if (rx_valid !== 1'b0 || got.size() != 1 || got[0] !== 8'h11) begin
      failures++;
      $display("FAIL overrun_drain: valid=%b bytes=%0d first=%h, want 0 1 11",
               rx_valid, got.size(), (got.size() > 0) ? got[0] : 8'hxx);
    end
  endtask

  task automatic test_stop_err_and_reset;
    rx_ready = 1'b1;
    pulse_clr();
    got.delete();
    drive_bits(8'h0F, odd_par(8'h0F), 1'b0, 11);
    RX = 1'b1;
    wait_cyc(6);
    checks++;
    if (stp_err !== 1'b1 || break_det !== 1'b0 || got.size() != 0 || break_active !== 1'b0) begin
      failures++;
      $display("FAIL stop_err: stp=%b brk=%b bytes=%0d active=%b, want 1 0 0 0", stp_err, break_det, got.size(), break_active);
    end
    drive_bits(8'h66, odd_par(8'h66), 1'b1, 5);
    #2;
    Rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_data, rx_valid, par_err, stp_err, break_det, break_active, overrun} !== 14'h0) begin
      failures++;
      $display("FAIL reset_mid: data=%h valid=%b flags=%b, want 00 0 00000", rx_data, rx_valid,
               {par_err, stp_err, break_det, break_active, overrun});
    end
    RX = 1'b1;
    wait_cyc(2);
    Rst_n = 1'b1;
    wait_cyc(12 * B);
    checks++;
    if (got.size() != 0 || rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_partial: bytes=%0d valid=%b, want 0 0", got.size(), rx_valid);
    end
    send_good(8'hC3);
    checks++;
    if (got.size() != 1 || got[0] !== 8'hC3) begin
      failures++;
      $display("FAIL reset_recover: got %0d bytes first=%h, want 1 byte C3", got.size(), (got.size() > 0) ? got[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    logic bad;
    logic exp_par;
    rx_ready = 1'b1;
    pulse_clr();
    got.delete();
    exp_q.delete();
    exp_par = 1'b0;
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      drive_bits(d, odd_par(d) ^ bad, 1'b1, 11);
      if (bad) exp_par = 1'b1;
      else exp_q.push_back(d);
    end
    RX = 1'b1;
    wait_cyc(6);
    checks++;
    if (got.size() != exp_q.size()) begin
      failures++;
      $display("FAIL b2b_count: got %0d bytes, want %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_byte%0d: got %h, want %h", i, got[i], exp_q[i]);
      end
    end
    checks++;
    if (par_err !== exp_par || stp_err !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b_flags: par=%b stp=%b ovr=%b, want %b 0 0", par_err, stp_err, overrun, exp_par);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_glitch();
    test_break();
    test_overrun();
    test_stop_err_and_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
